multicycle_alu: RTL and testbench
=================================

Name: multicycle_alu

Overview:
- Registered, parametrised ALU for the multicycle MIPS datapath; successor to the single-cycle combinational ALU.
- Adds correct signed/unsigned handling for SLT/SLTU and an arithmetic SRA.
- Adds iterative MULT/MULTU/DIV/DIVU with HI/LO registers, and a start/busy/done handshake so the control FSM can stall the EX state until completion.

Parameters:
- WIDTH, 32, operand/result width; must be a power of two, at least 8.
- OP_WIDTH, 5, width of ALUOp.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- start  input  1  launch operation; sampled only in IDLE
- ALUOp  input  OP_WIDTH  operation select, captured at start
- srcA  input  WIDTH  operand A, captured at start
- srcB  input  WIDTH  operand B; low log2(WIDTH) bits are the shift amount; captured at start
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse; ALUResult and Zero are valid and held until the next done
- Zero  output  1  registered (srcA == srcB) of the captured operands
- ALUResult  output  WIDTH  registered result
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- divByZero  output  1  registered flag, valid with done on a DIV/DIVU

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset value of every output is 0: busy, done, Zero, ALUResult, hi, lo, divByZero.
- Reset mid-operation aborts the operation. The FSM returns to IDLE and hi/lo are cleared; no done is produced.
- Opcode encoding:
  - ADD 0, ADDU 1, SUB 2, SUBU 3, AND 4, OR 5, XOR 6, NOR 7
  - SLT 8 (signed), SLTU 9 (unsigned)
  - SLL 10, SRL 11, SRA 12 (shifts apply to srcA by the shift amount; SRA sign-fills)
  - LUI 13 (srcB << WIDTH/2)
  - MULT 16, MULTU 17, DIV 18, DIVU 19
  - MFHI 20, MFLO 21 (ALUResult = hi / lo)
  - Any other code: ALUResult = 0, latency 1.
- Arithmetic wraps modulo 2^WIDTH. ADD/SUB and ADDU/SUBU produce identical results.
- FSM states: IDLE, MUL, DIV, FIN.
  - IDLE + start with a single-cycle op: go to FIN. Result is registered and done pulses in the next cycle (latency 1). busy is never asserted.
  - IDLE + start with MULT/MULTU: go to MUL. Shift-add runs one bit per cycle for WIDTH cycles, then FIN. done arrives WIDTH+1 cycles after start.
  - IDLE + start with DIV/DIVU and srcB != 0: go to DIV. Restoring division runs WIDTH cycles, then FIN. done arrives at WIDTH+1 cycles.
  - FIN: assert done, update hi/lo (mul/div only), return to IDLE. FIN accepts no start.
- Multiply: {hi,lo} = full 2*WIDTH-bit product. MULT is signed; it takes magnitudes and negates the product when the operand signs differ.
- Divide: lo = quotient, hi = remainder.
  - DIV truncates toward zero. The remainder takes the sign of the dividend.
  - DIV of most-negative / -1 gives lo = most-negative, hi = 0.
- Divide by zero: latency 1 (no DIV state). hi = srcA, lo = all ones, divByZero = 1.
- divByZero is cleared on any other accepted start.
- Operation results and registers:
  - Mul/div: ALUResult = lo.
  - hi/lo change only in FIN for mul/div ops. They are readable at any time.
  - MFHI/MFLO issued the cycle after a mul/div done return the new values.
- start while busy or in FIN is ignored. Captured operands are not disturbed.
- start held high continuously issues back-to-back operations; each is accepted in IDLE.

Optional Feature:
- Macro: ALU_OVERFLOW_EN.
- When defined:
  - Adds output port overflow (1 bit), reset 0.
  - overflow is registered with done. It is set for ADD/SUB signed overflow (operands of equal sign, result of differing sign, for ADD; analogous for SUB).
  - overflow is cleared for all other ops.
- When not defined: the port is absent and no overflow logic is built.

Test Plan:
- Reset then ADD srcA=0x7FFFFFFF, srcB=1: done 1 cycle later, ALUResult=0x80000000, Zero=0; with ALU_OVERFLOW_EN, overflow=1.
- SLT with A=0xFFFFFFFF, B=1 gives 1; SLTU on the same operands gives 0. SRA of A=0x80000000 by 4 gives 0xF8000000; SRL gives 0x08000000.
- MULT A=-3 (0xFFFFFFFD), B=7: busy for 32 cycles, done at cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULTU 0xFFFFFFFF*0xFFFFFFFF gives hi=0xFFFFFFFE, lo=1.
- DIV A=-7, B=2 gives lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU A=100, B=0 gives done in 1 cycle, divByZero=1, hi=100, lo=0xFFFFFFFF.
- During a MULT: start pulsed at cycle 5 with ADD is ignored (result is still the product). Reset asserted at cycle 10 gives busy=0, hi=lo=0 next cycle and no done.
- MULT 6*7 then MFLO issued on the cycle after done: ALUResult=42; MFHI gives 0.

Source files
------------

// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_alu
// Purpose  : Registered ALU for the multicycle MIPS datapath. Single-cycle
//            arithmetic/logic/shift ops complete with latency 1; MULT/MULTU
//            (shift-add) and DIV/DIVU (restoring) iterate one bit per cycle
//            and write the HI/LO registers. A start/busy/done handshake lets
//            the control FSM stall the EX state until the result is ready.
// Ports    : clk, reset (sync, active-high), start, ALUOp, srcA, srcB
//            busy, done, Zero, ALUResult, hi, lo, divByZero
//            overflow (only when ALU_OVERFLOW_EN is defined)
// Options  : `define ALU_OVERFLOW_EN adds the signed ADD/SUB overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_alu #(
    parameter int WIDTH    = 32,
    parameter int OP_WIDTH = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [OP_WIDTH-1:0] ALUOp,
    input  logic [WIDTH-1:0]    srcA,
    input  logic [WIDTH-1:0]    srcB,
    output logic                busy,
    output logic                done,
    output logic                Zero,
    output logic [WIDTH-1:0]    ALUResult,
    output logic [WIDTH-1:0]    hi,
    output logic [WIDTH-1:0]    lo,
    output logic                divByZero
`ifdef ALU_OVERFLOW_EN
    ,
    output logic                overflow
`endif
);

    localparam int c_SHW = $clog2(WIDTH);

    localparam logic [OP_WIDTH-1:0] c_OP_ADD   = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] c_OP_ADDU  = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] c_OP_SUB   = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] c_OP_SUBU  = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] c_OP_AND   = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] c_OP_OR    = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] c_OP_XOR   = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] c_OP_NOR   = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] c_OP_SLT   = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] c_OP_SLTU  = OP_WIDTH'(9);
    localparam logic [OP_WIDTH-1:0] c_OP_SLL   = OP_WIDTH'(10);
    localparam logic [OP_WIDTH-1:0] c_OP_SRL   = OP_WIDTH'(11);
    localparam logic [OP_WIDTH-1:0] c_OP_SRA   = OP_WIDTH'(12);
    localparam logic [OP_WIDTH-1:0] c_OP_LUI   = OP_WIDTH'(13);
    localparam logic [OP_WIDTH-1:0] c_OP_MULT  = OP_WIDTH'(16);
    localparam logic [OP_WIDTH-1:0] c_OP_MULTU = OP_WIDTH'(17);
    localparam logic [OP_WIDTH-1:0] c_OP_DIV   = OP_WIDTH'(18);
    localparam logic [OP_WIDTH-1:0] c_OP_DIVU  = OP_WIDTH'(19);
    localparam logic [OP_WIDTH-1:0] c_OP_MFHI  = OP_WIDTH'(20);
    localparam logic [OP_WIDTH-1:0] c_OP_MFLO  = OP_WIDTH'(21);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_MUL  = 2'd1;
    localparam logic [1:0] c_ST_DIV  = 2'd2;
    localparam logic [1:0] c_ST_FIN  = 2'd3;

    logic [1:0]         r_state;
    logic [c_SHW-1:0]   r_cnt;
    logic               r_done;
    logic               r_zero;
    logic               r_eq;
    logic               r_dbz;
    logic               r_neg;      // product sign (mul) or quotient sign (div)
    logic               r_rneg;     // remainder sign (div)
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_mp;       // {partial product, remaining multiplier}
    logic [WIDTH-1:0]   r_dvsr;
    logic [WIDTH-1:0]   r_quo;      // dividend shifts out as quotient shifts in
    logic [WIDTH-1:0]   r_rem;

    logic               w_is_mul;
    logic               w_is_div;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_b_zero;
    logic [WIDTH-1:0]   w_amag;
    logic [WIDTH-1:0]   w_bmag;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_alu;
    logic [c_SHW-1:0]   w_shamt;

    logic [WIDTH:0]     w_madd;
    logic [2*WIDTH-1:0] w_mstep;
    logic [2*WIDTH-1:0] w_mprod;

    logic [WIDTH:0]     w_rs;
    logic               w_dge;
    logic [WIDTH-1:0]   w_rem_n;
    logic [WIDTH-1:0]   w_quo_n;
    logic [WIDTH-1:0]   w_qfin;
    logic [WIDTH-1:0]   w_rfin;

    assign w_is_mul = (ALUOp == c_OP_MULT) || (ALUOp == c_OP_MULTU);
    assign w_is_div = (ALUOp == c_OP_DIV)  || (ALUOp == c_OP_DIVU);
    assign w_signed = (ALUOp == c_OP_MULT) || (ALUOp == c_OP_DIV);
    assign w_a_neg  = w_signed & srcA[WIDTH-1];
    assign w_b_neg  = w_signed & srcB[WIDTH-1];
    assign w_b_zero = (srcB == '0);
    // Magnitude of the most-negative value wraps to itself, which is the
    // correct unsigned magnitude.
    assign w_amag   = w_a_neg ? ('0 - srcA) : srcA;
    assign w_bmag   = w_b_neg ? ('0 - srcB) : srcB;
    assign w_sum    = srcA + srcB;
    assign w_diff   = srcA - srcB;
    assign w_shamt  = srcB[c_SHW-1:0];

    always_comb begin
        w_alu = '0;
        case (ALUOp)
            c_OP_ADD, c_OP_ADDU: w_alu = w_sum;
            c_OP_SUB, c_OP_SUBU: w_alu = w_diff;
            c_OP_AND:            w_alu = srcA & srcB;
            c_OP_OR:             w_alu = srcA | srcB;
            c_OP_XOR:            w_alu = srcA ^ srcB;
            c_OP_NOR:            w_alu = ~(srcA | srcB);
            c_OP_SLT:            w_alu = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
            c_OP_SLTU:           w_alu = {{(WIDTH-1){1'b0}}, (srcA < srcB)};
            c_OP_SLL:            w_alu = srcA << w_shamt;
            c_OP_SRL:            w_alu = srcA >> w_shamt;
            c_OP_SRA:            w_alu = $signed(srcA) >>> w_shamt;
            c_OP_LUI:            w_alu = srcB << (WIDTH/2);
            c_OP_MFHI:           w_alu = r_hi;
            c_OP_MFLO:           w_alu = r_lo;
            default:             w_alu = '0;
        endcase
    end

    // Shift-add step: add multiplicand when the multiplier LSB is set, then
    // shift the whole {sum, multiplier} pair right one bit.
    assign w_madd  = {1'b0, r_mp[2*WIDTH-1:WIDTH]} + (r_mp[0] ? {1'b0, r_mcand} : '0);
    assign w_mstep = {w_madd, r_mp[WIDTH-1:1]};
    assign w_mprod = r_neg ? ('0 - w_mstep) : w_mstep;

    // Restoring division step on magnitudes. The trial remainder needs one
    // extra bit; after a successful subtract the result is below the divisor.
    assign w_rs    = {r_rem, r_quo[WIDTH-1]};
    assign w_dge   = (w_rs >= {1'b0, r_dvsr});
    assign w_rem_n = w_dge ? (w_rs[WIDTH-1:0] - r_dvsr) : w_rs[WIDTH-1:0];
    assign w_quo_n = {r_quo[WIDTH-2:0], w_dge};
    assign w_qfin  = r_neg  ? ('0 - w_quo_n) : w_quo_n;
    assign w_rfin  = r_rneg ? ('0 - w_rem_n) : w_rem_n;

`ifdef ALU_OVERFLOW_EN
    logic w_ovf;
    logic r_ovf;

    always_comb begin
        w_ovf = 1'b0;
        if (ALUOp == c_OP_ADD) begin
            w_ovf = (srcA[WIDTH-1] == srcB[WIDTH-1]) && (w_sum[WIDTH-1] != srcA[WIDTH-1]);
        end else if (ALUOp == c_OP_SUB) begin
            w_ovf = (srcA[WIDTH-1] != srcB[WIDTH-1]) && (w_diff[WIDTH-1] != srcA[WIDTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if ((r_state == c_ST_IDLE) && start) begin
            r_ovf <= w_ovf;
        end
    end

    assign overflow = r_ovf;
`endif

    // All visible results (ALUResult, Zero, hi, lo) are committed on the edge
    // that enters FIN, so they are already valid in the cycle done is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_zero   <= 1'b0;
            r_eq     <= 1'b0;
            r_dbz    <= 1'b0;
            r_neg    <= 1'b0;
            r_rneg   <= 1'b0;
            r_result <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_mcand  <= '0;
            r_mp     <= '0;
            r_dvsr   <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_eq  <= (srcA == srcB);
                        r_dbz <= w_is_div & w_b_zero;
                        r_cnt <= '0;
                        if (w_is_mul) begin
                            r_state <= c_ST_MUL;
                            r_neg   <= w_a_neg ^ w_b_neg;
                            r_mcand <= w_amag;
                            r_mp    <= {{WIDTH{1'b0}}, w_bmag};
                        end else if (w_is_div && !w_b_zero) begin
                            r_state <= c_ST_DIV;
                            r_neg   <= w_a_neg ^ w_b_neg;
                            r_rneg  <= w_a_neg;
                            r_dvsr  <= w_bmag;
                            r_quo   <= w_amag;
                            r_rem   <= '0;
                        end else begin
                            r_state <= c_ST_FIN;
                            r_done  <= 1'b1;
                            r_zero  <= (srcA == srcB);
                            if (w_is_div) begin
                                // Divide by zero: finish immediately.
                                r_hi     <= srcA;
                                r_lo     <= '1;
                                r_result <= '1;
                            end else begin
                                r_result <= w_alu;
                            end
                        end
                    end
                end
                c_ST_MUL: begin
                    r_mp  <= w_mstep;
                    r_cnt <= r_cnt + c_SHW'(1);
                    if (&r_cnt) begin
                        r_state  <= c_ST_FIN;
                        r_done   <= 1'b1;
                        r_zero   <= r_eq;
                        r_hi     <= w_mprod[2*WIDTH-1:WIDTH];
                        r_lo     <= w_mprod[WIDTH-1:0];
                        r_result <= w_mprod[WIDTH-1:0];
                    end
                end
                c_ST_DIV: begin
                    r_rem <= w_rem_n;
                    r_quo <= w_quo_n;
                    r_cnt <= r_cnt + c_SHW'(1);
                    if (&r_cnt) begin
                        r_state  <= c_ST_FIN;
                        r_done   <= 1'b1;
                        r_zero   <= r_eq;
                        r_hi     <= w_rfin;
                        r_lo     <= w_qfin;
                        r_result <= w_qfin;
                    end
                end
                default: begin
                    // FIN: done is high this cycle; no start is accepted here.
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state == c_ST_MUL) || (r_state == c_ST_DIV);
    assign done      = r_done;
    assign Zero      = r_zero;
    assign ALUResult = r_result;
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign divByZero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_alu
// Purpose  : Self-checking bench for multicycle_alu (WIDTH=32). Expected
//            results come from a behavioural model using 64-bit arithmetic
//            and are queued at issue, then popped when done is observed.
// Options  : honours ALU_OVERFLOW_EN for the overflow port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  ALUOp;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic        done;
    logic        Zero;
    logic [31:0] ALUResult;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        divByZero;
`ifdef ALU_OVERFLOW_EN
    logic        overflow;
`endif

    always #5 clk = ~clk;

    multicycle_alu #(.WIDTH(32), .OP_WIDTH(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ALUOp     (ALUOp),
        .srcA      (srcA),
        .srcB      (srcB),
        .busy      (busy),
        .done      (done),
        .Zero      (Zero),
        .ALUResult (ALUResult),
        .hi        (hi),
        .lo        (lo),
        .divByZero (divByZero)
`ifdef ALU_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        zero;
        logic        dbz;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          n_checks;
    int          n_errors;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model; tracks its own HI/LO.
    task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output exp_t e);
        longint      sa;
        longint      sbv;
        longint      p;
        longint      q;
        longint      r;
        logic [63:0] up;
        logic [31:0] s;
        logic [31:0] d;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        s   = a + b;
        d   = a - b;
        e.res  = 32'h0;
        e.zero = (a == b);
        e.dbz  = 1'b0;
        e.ovf  = 1'b0;
        e.lat  = 1;
        case (op)
            5'd0, 5'd1: e.res = s;
            5'd2, 5'd3: e.res = d;
            5'd4:  e.res = a & b;
            5'd5:  e.res = a | b;
            5'd6:  e.res = a ^ b;
            5'd7:  e.res = ~(a | b);
            5'd8:  e.res = (sa < sbv) ? 32'd1 : 32'd0;
            5'd9:  e.res = (a < b) ? 32'd1 : 32'd0;
            5'd10: e.res = a << b[4:0];
            5'd11: e.res = a >> b[4:0];
            5'd12: begin p = sa >>> b[4:0]; e.res = p[31:0]; end
            5'd13: e.res = b << 16;
            5'd16: begin
                p = sa * sbv; m_hi = p[63:32]; m_lo = p[31:0]; e.lat = 33;
            end
            5'd17: begin
                up = {32'h0, a} * {32'h0, b}; m_hi = up[63:32]; m_lo = up[31:0]; e.lat = 33;
            end
            5'd18: begin
                if (b == 32'h0) begin
                    m_hi = a; m_lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
                end else begin
                    q = sa / sbv; r = sa % sbv;
                    m_lo = q[31:0]; m_hi = r[31:0]; e.lat = 33;
                end
            end
            5'd19: begin
                if (b == 32'h0) begin
                    m_hi = a; m_lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
                end else begin
                    m_lo = a / b; m_hi = a % b; e.lat = 33;
                end
            end
            5'd20: e.res = m_hi;
            5'd21: e.res = m_lo;
            default: e.res = 32'h0;
        endcase
        if (op >= 5'd16 && op <= 5'd19) e.res = m_lo;
        if (op == 5'd0) e.ovf = (a[31] == b[31]) && (s[31] != a[31]);
        if (op == 5'd2) e.ovf = (a[31] != b[31]) && (d[31] != a[31]);
        e.hi = m_hi;
        e.lo = m_lo;
    endtask

    // Issue one op; optionally pulse an ignored ADD start at cycle 'poke'.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int poke);
        exp_t e;
        exp_t g;
        int   lat;
        int   nb;
        bit   seen;
        model(op, a, b, e);
        sb.push_back(e);
        @(posedge clk); #1;
        ALUOp = op; srcA = a; srcB = b; start = 1'b1;
        nb = 0; seen = 1'b0; lat = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
            if (poke != 0 && k == poke) begin
                start = 1'b1; ALUOp = 5'd0; srcA = 32'h1; srcB = 32'h2;
            end
            if (poke != 0 && k == poke + 1) start = 1'b0;
            if (busy) nb++;
            if (done) begin
                seen = 1'b1;
                lat  = k;
                break;
            end
        end
        g = sb.pop_front();
        check_val($sformatf("op%0d_done_seen", op), 64'(seen), 64'd1);
        if (seen) begin
            check_val($sformatf("op%0d_latency", op), 64'(lat), 64'(g.lat));
            check_val($sformatf("op%0d_busy_cycles", op), 64'(nb), 64'(g.lat - 1));
            check_val($sformatf("op%0d_result", op), 64'(ALUResult), 64'(g.res));
            check_val($sformatf("op%0d_hi", op), 64'(hi), 64'(g.hi));
            check_val($sformatf("op%0d_lo", op), 64'(lo), 64'(g.lo));
            check_val($sformatf("op%0d_zero", op), 64'(Zero), 64'(g.zero));
            check_val($sformatf("op%0d_divbyzero", op), 64'(divByZero), 64'(g.dbz));
`ifdef ALU_OVERFLOW_EN
            check_val($sformatf("op%0d_overflow", op), 64'(overflow), 64'(g.ovf));
`endif
        end
    endtask

    // Start a MULT, assert reset mid-way, confirm abort and no done.
    task automatic reset_mid();
        bit late_done;
        @(posedge clk); #1;
        ALUOp = 5'd16; srcA = 32'd11; srcB = 32'd13; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check_val("mid_busy_before_reset", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_hi = 32'h0;
        m_lo = 32'h0;
        check_val("reset_mid_busy", 64'(busy), 64'd0);
        check_val("reset_mid_hi", 64'(hi), 64'd0);
        check_val("reset_mid_lo", 64'(lo), 64'd0);
        late_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) late_done = 1'b1;
        end
        check_val("reset_mid_no_done", 64'(late_done), 64'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_hi = 32'h0;
        m_lo = 32'h0;
        reset = 1'b1;
        start = 1'b0;
        ALUOp = 5'd0;
        srcA  = 32'h0;
        srcB  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_zero", 64'(Zero), 64'd0);
        check_val("rst_result", 64'(ALUResult), 64'd0);
        check_val("rst_hi", 64'(hi), 64'd0);
        check_val("rst_lo", 64'(lo), 64'd0);
        check_val("rst_divbyzero", 64'(divByZero), 64'd0);
`ifdef ALU_OVERFLOW_EN
        check_val("rst_overflow", 64'(overflow), 64'd0);
`endif
        reset = 1'b0;

        // Single-cycle ops
        run_op(5'd0,  32'h7FFF_FFFF, 32'h1,         0);
        run_op(5'd2,  32'h5,         32'h5,         0);
        run_op(5'd2,  32'h8000_0000, 32'h1,         0);
        run_op(5'd8,  32'hFFFF_FFFF, 32'h1,         0);
        run_op(5'd9,  32'hFFFF_FFFF, 32'h1,         0);
        run_op(5'd12, 32'h8000_0000, 32'h4,         0);
        run_op(5'd11, 32'h8000_0000, 32'h4,         0);
        run_op(5'd10, 32'h1,         32'h1F,        0);
        run_op(5'd13, 32'h0,         32'h1234,      0);
        run_op(5'd7,  32'hF0F0_0000, 32'h0F0F_0000, 0);
        run_op(5'd6,  32'hA5A5_A5A5, 32'hFFFF_0000, 0);
        run_op(5'd31, 32'h5,         32'h6,         0);

        // Multiply
        run_op(5'd16, 32'hFFFF_FFFD, 32'h7,         0);
        run_op(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(5'd16, 32'h6,         32'h7,         5);
        run_op(5'd21, 32'h0,         32'h0,         0);
        run_op(5'd20, 32'h0,         32'h0,         0);

        // Divide
        run_op(5'd18, 32'hFFFF_FFF9, 32'h2,         0);
        run_op(5'd19, 32'd100,       32'd7,         0);
        run_op(5'd18, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(5'd19, 32'd100,       32'h0,         0);
        run_op(5'd1,  32'h3,         32'h4,         0);

        // Reset during a multiply
        reset_mid();
        run_op(5'd21, 32'h0,         32'h0,         0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
